// File: rtl/uart_word_bridge.sv
// Word <-> byte bridge for the UART core: the TX side splits a word into bytes,
// the RX side assembles bytes into a word behind a one-entry output buffer.
//
// TX state | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a word, tx_ready high
// SEND     | presenting byte[index] to the UART core until accepted
module uart_word_bridge #(
    parameter int TX_BYTES   = 4,
    parameter int RX_BYTES   = 8,
    parameter int MSB_FIRST  = 1,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*TX_BYTES-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            byte_tx_data,
    output logic                  byte_tx_valid,
    input  logic                  byte_tx_ready,
    input  logic [7:0]            byte_rx_data,
    input  logic                  byte_rx_valid,
    input  logic                  byte_rx_error,
    output logic [8*RX_BYTES-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overflow,
    output logic                  rx_frame_err,
    output logic                  rx_timeout
);

    localparam int TXIW   = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
    localparam int RXIW   = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
    localparam int TMW    = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam int TM_LIM = (RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0;

    localparam logic [TXIW-1:0] TX_LAST = TXIW'(TX_BYTES - 1);
    localparam logic [RXIW-1:0] RX_LAST = RXIW'(RX_BYTES - 1);
    localparam logic [TMW-1:0]  TM_END  = TMW'(TM_LIM);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]            tx_state;
    logic [8*TX_BYTES-1:0] tx_word;
    logic [TXIW-1:0]       tx_idx;
    logic [TXIW-1:0]       tx_slot;

    logic [RXIW-1:0]       rx_idx;
    logic [RXIW-1:0]       rx_slot;
    logic [8*RX_BYTES-1:0] rx_asm;
    logic [8*RX_BYTES-1:0] rx_asm_next;
    logic [TMW-1:0]        rx_timer;
    logic                  rx_good;
    logic                  rx_done;
    logic                  rx_load;

    // ---------------- TX path ----------------
    assign tx_ready      = (tx_state == ST_IDLE);
    assign byte_tx_valid = (tx_state == ST_SEND);

    always_comb begin
        tx_slot      = (MSB_FIRST != 0) ? (TX_LAST - tx_idx) : tx_idx;
        byte_tx_data = 8'h00;
        if (tx_state == ST_SEND) begin
            byte_tx_data = tx_word[{tx_slot, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_word  <= '0;
            tx_idx   <= '0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        tx_word  <= tx_data;
                        tx_idx   <= '0;
                        tx_state <= ST_SEND;
                    end
                end
                default: begin
                    if (byte_tx_ready) begin
                        if (tx_idx == TX_LAST) begin
                            tx_state <= ST_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- RX path ----------------
    always_comb begin
        rx_slot     = (MSB_FIRST != 0) ? (RX_LAST - rx_idx) : rx_idx;
        rx_asm_next = rx_asm;
        rx_asm_next[{rx_slot, 3'b000} +: 8] = byte_rx_data;
    end

    assign rx_good = byte_rx_valid && !byte_rx_error;
    assign rx_done = rx_good && (rx_idx == RX_LAST);
    // The buffer can take a new word if empty or being drained on this same edge.
    assign rx_load = rx_done && (!rx_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_idx       <= '0;
            rx_asm       <= '0;
            rx_timer     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_timeout   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_timeout   <= 1'b0;

            if (byte_rx_valid) begin
                rx_timer <= '0;
                if (byte_rx_error) begin
                    rx_idx       <= '0;
                    rx_frame_err <= 1'b1;
                end else begin
                    rx_asm <= rx_asm_next;
                    rx_idx <= rx_done ? '0 : rx_idx + 1'b1;
                end
            end else if ((RX_TIMEOUT > 0) && (rx_idx != '0)) begin
                // Timer saturates into the abort rather than ever wrapping.
                if (rx_timer == TM_END) begin
                    rx_idx     <= '0;
                    rx_timer   <= '0;
                    rx_timeout <= 1'b1;
                end else begin
                    rx_timer <= rx_timer + 1'b1;
                end
            end else begin
                rx_timer <= '0;
            end

            if (rx_load) begin
                rx_data  <= rx_asm_next;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && !rx_load) begin
                rx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Bench for uart_word_bridge: an MSB-first and an LSB-first instance, with byte
// and word scoreboards fed by the stimulus tasks and drained by edge monitors.
module tb_uart_word_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] tx_data, tx_data_l;
    logic        tx_valid, tx_valid_l;
    logic        byte_tx_ready, byte_tx_ready_l;
    logic        tx_ready, tx_ready_l;
    logic [7:0]  byte_tx_data, byte_tx_data_l;
    logic        byte_tx_valid, byte_tx_valid_l;
    logic [7:0]  byte_rx_data;
    logic        byte_rx_valid, byte_rx_error;
    logic        rx_ready;
    logic [63:0] rx_data, rx_data_l;
    logic        rx_valid, rx_valid_l;
    logic        rx_overflow, rx_overflow_l;
    logic        rx_frame_err, rx_frame_err_l;
    logic        rx_timeout, rx_timeout_l;

    int tests = 0;
    int fails = 0;

    logic [7:0]  txq_m[$];
    logic [7:0]  txq_l[$];
    logic [63:0] rxq[$];

    uart_word_bridge #(.TX_BYTES(4), .RX_BYTES(8), .MSB_FIRST(1), .RX_TIMEOUT(50)) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .byte_tx_data(byte_tx_data), .byte_tx_valid(byte_tx_valid), .byte_tx_ready(byte_tx_ready),
        .byte_rx_data(byte_rx_data), .byte_rx_valid(byte_rx_valid), .byte_rx_error(byte_rx_error),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err), .rx_timeout(rx_timeout)
    );

    uart_word_bridge #(.TX_BYTES(4), .RX_BYTES(8), .MSB_FIRST(0), .RX_TIMEOUT(50)) dut_l (
        .clk(clk), .reset(reset),
        .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready_l),
        .byte_tx_data(byte_tx_data_l), .byte_tx_valid(byte_tx_valid_l), .byte_tx_ready(byte_tx_ready_l),
        .byte_rx_data(byte_rx_data), .byte_rx_valid(byte_rx_valid), .byte_rx_error(byte_rx_error),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow_l), .rx_frame_err(rx_frame_err_l), .rx_timeout(rx_timeout_l)
    );

    // Monitors look half a cycle before the edge on which a transfer happens.
    always @(negedge clk) begin
        if (!reset && byte_tx_valid && byte_tx_ready) begin
            tests++;
            if (txq_m.size() == 0) begin
                fails++;
                $display("FAIL tx_msb_byte: got unexpected %0h, expected none", byte_tx_data);
            end else begin
                logic [7:0] e;
                e = txq_m.pop_front();
                if (byte_tx_data !== e) begin
                    fails++;
                    $display("FAIL tx_msb_byte: got %0h expected %0h", byte_tx_data, e);
                end
            end
        end
        if (!reset && byte_tx_valid_l && byte_tx_ready_l) begin
            tests++;
            if (txq_l.size() == 0) begin
                fails++;
                $display("FAIL tx_lsb_byte: got unexpected %0h, expected none", byte_tx_data_l);
            end else begin
                logic [7:0] e;
                e = txq_l.pop_front();
                if (byte_tx_data_l !== e) begin
                    fails++;
                    $display("FAIL tx_lsb_byte: got %0h expected %0h", byte_tx_data_l, e);
                end
            end
        end
        if (!reset && rx_valid && rx_ready) begin
            tests++;
            if (rxq.size() == 0) begin
                fails++;
                $display("FAIL rx_word: got unexpected %0h, expected none", rx_data);
            end else begin
                logic [63:0] e;
                e = rxq.pop_front();
                if (rx_data !== e) begin
                    fails++;
                    $display("FAIL rx_word: got %0h expected %0h", rx_data, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic err);
        byte_rx_data  = b;
        byte_rx_valid = 1'b1;
        byte_rx_error = err;
        tick();
        byte_rx_valid = 1'b0;
        byte_rx_error = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({tx_ready, byte_tx_valid, byte_tx_data, rx_valid, rx_overflow, rx_frame_err, rx_timeout} !== 14'h2000) begin
            fails++;
            $display("FAIL reset_ctrl: got %0h expected 2000",
                     {tx_ready, byte_tx_valid, byte_tx_data, rx_valid, rx_overflow, rx_frame_err, rx_timeout});
        end
        tests++;
        if (rx_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_rx_data: got %0h expected 0", rx_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_tx_msb;
        byte_tx_ready = 1'b1;
        txq_m.push_back(8'hDE); txq_m.push_back(8'hAD);
        txq_m.push_back(8'hBE); txq_m.push_back(8'hEF);
        tx_data  = 32'hDEADBEEF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tests++;
        if (byte_tx_valid !== 1'b1 || byte_tx_data !== 8'hDE) begin
            fails++;
            $display("FAIL tx_first_byte: got v=%0b d=%0h expected v=1 d=de", byte_tx_valid, byte_tx_data);
        end
        repeat (3) tick();
        tests++;
        if (tx_ready !== 1'b0 || byte_tx_data !== 8'hEF) begin
            fails++;
            $display("FAIL tx_last_byte: got rdy=%0b d=%0h expected rdy=0 d=ef", tx_ready, byte_tx_data);
        end
        tick();
        tests++;
        if (tx_ready !== 1'b1 || byte_tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL tx_ready_return: got rdy=%0b v=%0b expected rdy=1 v=0", tx_ready, byte_tx_valid);
        end
        tests++;
        if (txq_m.size() != 0) begin
            fails++;
            $display("FAIL tx_msb_count: got %0d left expected 0", txq_m.size());
        end
    endtask

    task automatic test_tx_lsb_stall;
        logic [31:0] w;
        logic [7:0]  e;
        w = 32'hDEADBEEF;
        byte_tx_ready_l = 1'b0;
        for (int k = 0; k < 4; k++) txq_l.push_back(8'(w >> (8 * k)));
        tx_data_l  = w;
        tx_valid_l = 1'b1;
        tick();
        tx_valid_l = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = 8'(w >> (8 * k));
            for (int s = 0; s < 10; s++) begin
                tests++;
                if (byte_tx_valid_l !== 1'b1 || byte_tx_data_l !== e) begin
                    fails++;
                    $display("FAIL tx_stall_hold: got v=%0b d=%0h expected v=1 d=%0h", byte_tx_valid_l, byte_tx_data_l, e);
                end
                tick();
            end
            byte_tx_ready_l = 1'b1;
            tick();
            byte_tx_ready_l = 1'b0;
        end
        tests++;
        if (tx_ready_l !== 1'b1 || byte_tx_valid_l !== 1'b0 || txq_l.size() != 0) begin
            fails++;
            $display("FAIL tx_lsb_done: got rdy=%0b v=%0b left=%0d expected rdy=1 v=0 left=0",
                     tx_ready_l, byte_tx_valid_l, txq_l.size());
        end
    endtask

    task automatic test_rx_stall;
        logic [63:0] w;
        w = 64'h0102030405060708;
        rx_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send_rx(8'(i), 1'b0);
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_early_valid: got %0b expected 0", rx_valid);
        end
        rxq.push_back(w);
        send_rx(8'h08, 1'b0);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== w) begin
            fails++;
            $display("FAIL rx_word_msb: got v=%0b d=%0h expected v=1 d=%0h", rx_valid, rx_data, w);
        end
        tests++;
        if (rx_data_l !== 64'h0807060504030201) begin
            fails++;
            $display("FAIL rx_word_lsb: got %0h expected 0807060504030201", rx_data_l);
        end
        tests++;
        if (rx_overflow !== 1'b0) begin
            fails++;
            $display("FAIL rx_no_overflow: got %0b expected 0", rx_overflow);
        end
        repeat (20) begin
            tick();
            tests++;
            if (rx_valid !== 1'b1 || rx_data !== w) begin
                fails++;
                $display("FAIL rx_hold: got v=%0b d=%0h expected v=1 d=%0h", rx_valid, rx_data, w);
            end
        end
    endtask

    task automatic test_rx_overflow;
        for (int i = 0; i < 8; i++) send_rx(8'h11 + 8'(i), 1'b0);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 64'h0102030405060708 || rx_overflow !== 1'b1) begin
            fails++;
            $display("FAIL rx_overflow: got v=%0b d=%0h ovf=%0b expected v=1 d=0102030405060708 ovf=1",
                     rx_valid, rx_data, rx_overflow);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tests++;
        if (rx_valid !== 1'b0 || rx_overflow !== 1'b1) begin
            fails++;
            $display("FAIL rx_drain_sticky: got v=%0b ovf=%0b expected v=0 ovf=1", rx_valid, rx_overflow);
        end
    endtask

    task automatic test_rx_frame_err;
        rx_ready = 1'b1;
        send_rx(8'hA1, 1'b0); send_rx(8'hA2, 1'b0); send_rx(8'hA3, 1'b0);
        send_rx(8'hFF, 1'b1);
        tests++;
        if (rx_frame_err !== 1'b1) begin
            fails++;
            $display("FAIL frame_err_pulse: got %0b expected 1", rx_frame_err);
        end
        tick();
        tests++;
        if (rx_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL frame_err_width: got %0b expected 0", rx_frame_err);
        end
        send_rx(8'hFE, 1'b1);
        tests++;
        if (rx_frame_err !== 1'b1) begin
            fails++;
            $display("FAIL frame_err_idle: got %0b expected 1", rx_frame_err);
        end
        rxq.push_back(64'h2122232425262728);
        for (int i = 0; i < 8; i++) send_rx(8'h21 + 8'(i), 1'b0);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 64'h2122232425262728) begin
            fails++;
            $display("FAIL frame_err_next: got v=%0b d=%0h expected v=1 d=2122232425262728", rx_valid, rx_data);
        end
        tick();
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_consume: got %0b expected 0", rx_valid);
        end
    endtask

    task automatic test_rx_timeout;
        int hit;
        int seen;
        hit = 0;
        send_rx(8'hB1, 1'b0); send_rx(8'hB2, 1'b0); send_rx(8'hB3, 1'b0);
        for (int i = 1; i <= 80 && hit == 0; i++) begin
            tick();
            if (rx_timeout === 1'b1) hit = i;
        end
        tests++;
        if (hit < 48 || hit > 52) begin
            fails++;
            $display("FAIL timeout_delay: got %0d idle clocks expected about 50", hit);
        end
        tick();
        tests++;
        if (rx_timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_width: got %0b expected 0", rx_timeout);
        end
        rxq.push_back(64'hC1C2C3C4C5C6C7C8);
        for (int i = 0; i < 8; i++) send_rx(8'hC1 + 8'(i), 1'b0);
        tick();
        seen = 0;
        rxq.push_back(64'hD0D1D2D3D4D5D6D7);
        for (int i = 0; i < 8; i++) begin
            send_rx(8'hD0 + 8'(i), 1'b0);
            if (i < 7) begin
                repeat (40) begin
                    tick();
                    if (rx_timeout === 1'b1) seen++;
                end
            end
        end
        repeat (100) begin
            tick();
            if (rx_timeout === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL timeout_spurious: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_rx(8'hE1 + 8'(i), 1'b0);
        byte_tx_ready = 1'b1;
        txq_m.push_back(8'hAA); txq_m.push_back(8'hBB);
        tx_data  = 32'hAABBCCDD;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if ({tx_ready, byte_tx_valid, byte_tx_data, rx_valid, rx_overflow, rx_frame_err, rx_timeout} !== 14'h2000) begin
            fails++;
            $display("FAIL reset_mid_ctrl: got %0h expected 2000",
                     {tx_ready, byte_tx_valid, byte_tx_data, rx_valid, rx_overflow, rx_frame_err, rx_timeout});
        end
        tests++;
        if (rx_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_mid_rx_data: got %0h expected 0", rx_data);
        end
        reset = 1'b0;
        tick();
        txq_m.push_back(8'h01); txq_m.push_back(8'h02);
        txq_m.push_back(8'h03); txq_m.push_back(8'h04);
        tx_data  = 32'h01020304;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tests++;
        if (byte_tx_data !== 8'h01) begin
            fails++;
            $display("FAIL reset_tx_restart: got %0h expected 01", byte_tx_data);
        end
        repeat (4) tick();
        rxq.push_back(64'h3132333435363738);
        for (int i = 0; i < 8; i++) send_rx(8'h31 + 8'(i), 1'b0);
        tick();
        tick();
        tests++;
        if (txq_m.size() != 0 || rxq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got tx=%0d rx=%0d left expected 0 and 0", txq_m.size(), rxq.size());
        end
    endtask

    initial begin
        reset           = 1'b1;
        tx_data         = '0;
        tx_valid        = 1'b0;
        tx_data_l       = '0;
        tx_valid_l      = 1'b0;
        byte_tx_ready   = 1'b0;
        byte_tx_ready_l = 1'b0;
        byte_rx_data    = '0;
        byte_rx_valid   = 1'b0;
        byte_rx_error   = 1'b0;
        rx_ready        = 1'b0;

        test_reset();
        test_tx_msb();
        test_tx_lsb_stall();
        test_rx_stall();
        test_rx_overflow();
        test_rx_frame_err();
        test_rx_timeout();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
